// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A0   = 2'd1,
        ST_A1   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e decode_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: decode_size = SZ_BYTE;
            F3_LH, F3_LHU: decode_size = SZ_HALF;
            F3_LW:         decode_size = SZ_WORD;
            default:       decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input lsu_size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// Module      : lsu_align
// Description : Lane mask, store data shift and load extract/extend logic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          i_funct3,
    input  logic [1:0]          i_offset,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]   i_word0,
    input  logic [DATA_W-1:0]   i_mem_rd,
    output logic                o_cross,
    output logic [7:0]          o_mask,
    output logic [2*DATA_W-1:0] o_wd,
    output logic [DATA_W-1:0]   o_rdata
);

    lsu_size_e           w_size;
    logic [2:0]          w_bytes;
    logic [4:0]          w_shamt;
    logic                w_signed;
    logic [7:0]          w_base_mask;
    logic [2*DATA_W-1:0] w_ld;
    logic [2*DATA_W-1:0] w_sh;
    logic                w_unused_sh;

    assign w_size   = decode_size(i_funct3);
    assign w_bytes  = size_bytes(w_size);
    assign w_shamt  = {i_offset, 3'b000};
    assign w_signed = (i_funct3 == F3_LB) || (i_funct3 == F3_LH);
    // offset (max 3) plus size (max 4) fits in three bits
    assign o_cross  = ({1'b0, i_offset} + w_bytes) > 3'd4;

    always_comb begin
        w_base_mask = 8'h0F;
        case (w_size)
            SZ_BYTE: w_base_mask = 8'h01;
            SZ_HALF: w_base_mask = 8'h03;
            default: w_base_mask = 8'h0F;
        endcase
    end

    assign o_mask = w_base_mask << i_offset;
    assign o_wd   = {{DATA_W{1'b0}}, i_wdata} << w_shamt;

    assign w_ld        = o_cross ? {i_mem_rd, i_word0} : {{DATA_W{1'b0}}, i_mem_rd};
    assign w_sh        = w_ld >> w_shamt;
    assign w_unused_sh = ^w_sh[2*DATA_W-1:DATA_W];

    always_comb begin
        o_rdata = w_sh[DATA_W-1:0];
        case (w_size)
            SZ_BYTE: o_rdata = {{(DATA_W-8){w_signed & w_sh[7]}}, w_sh[7:0]};
            SZ_HALF: o_rdata = {{(DATA_W-16){w_signed & w_sh[15]}}, w_sh[15:0]};
            default: o_rdata = w_sh[DATA_W-1:0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit
// Description : Multi-cycle MEM-stage load/store unit with misaligned support.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_we,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    lsu_state_e            r_state_q,  w_state_d;
    logic                  r_write_q,  w_write_d;
    logic [2:0]            r_funct3_q, w_funct3_d;
    logic [DM_ADDRESS-1:0] r_addr_q,   w_addr_d;
    logic [DATA_W-1:0]     r_wdata_q,  w_wdata_d;
    logic [DATA_W-1:0]     r_word0_q,  w_word0_d;

    logic                  w_cross;
    logic [7:0]            w_mask;
    logic [2*DATA_W-1:0]   w_wd;
    logic [DATA_W-1:0]     w_ld_data;
    logic [DM_ADDRESS-3:0] w_word_idx;
    logic [DM_ADDRESS-3:0] w_next_idx;
    logic                  w_unused_addr;

    assign w_unused_addr = ^addr[31:DM_ADDRESS];
    assign w_word_idx    = r_addr_q[DM_ADDRESS-1:2];
    // Word index wraps naturally at the top of memory
    assign w_next_idx    = w_word_idx + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3 (r_funct3_q),
        .i_offset (r_addr_q[1:0]),
        .i_wdata  (r_wdata_q),
        .i_word0  (r_word0_q),
        .i_mem_rd (mem_rd),
        .o_cross  (w_cross),
        .o_mask   (w_mask),
        .o_wd     (w_wd),
        .o_rdata  (w_ld_data)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_write_d  = r_write_q;
        w_funct3_d = r_funct3_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_word0_d  = r_word0_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        rdata      = '0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 4'b0000;
        mem_wd     = '0;

        case (r_state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    stall      = 1'b1;
                    w_write_d  = req_write;
                    w_funct3_d = funct3;
                    w_addr_d   = addr[DM_ADDRESS-1:0];
                    w_wdata_d  = wdata;
                    w_state_d  = ST_A0;
                end
            end
            ST_A0: begin
                stall     = 1'b1;
                mem_addr  = {w_word_idx, 2'b00};
                mem_re    = ~r_write_q;
                mem_we    = r_write_q ? w_mask[3:0] : 4'b0000;
                mem_wd    = r_write_q ? w_wd[DATA_W-1:0] : '0;
                w_state_d = w_cross ? ST_A1 : ST_DONE;
            end
            ST_A1: begin
                stall     = 1'b1;
                mem_addr  = {w_next_idx, 2'b00};
                mem_re    = ~r_write_q;
                mem_we    = r_write_q ? w_mask[7:4] : 4'b0000;
                mem_wd    = r_write_q ? w_wd[2*DATA_W-1:DATA_W] : '0;
                w_word0_d = mem_rd;
                w_state_d = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                rdata      = r_write_q ? '0 : w_ld_data;
                w_state_d  = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Reset silences all handshake and memory strobes immediately
        if (reset) begin
            stall      = 1'b0;
            resp_valid = 1'b0;
            rdata      = '0;
            mem_addr   = '0;
            mem_re     = 1'b0;
            mem_we     = 4'b0000;
            mem_wd     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_write_q  <= 1'b0;
            r_funct3_q <= 3'b000;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_word0_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_write_q  <= w_write_d;
            r_funct3_q <= w_funct3_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_word0_q  <= w_word0_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with byte-level memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

    localparam int DM = 9;
    localparam int MEM_BYTES = 1 << DM;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [2:0]    funct3;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          stall;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic [DM-1:0] mem_addr;
    logic          mem_re;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    load_store_unit #(.DM_ADDRESS(DM), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory attached to the DUT, preloaded from init_img
    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] init_img[MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    bit         init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_img[i];
        end else begin
            if (mem_re)
                mem_rd <= {mem[mem_addr + 3], mem[mem_addr + 2], mem[mem_addr + 1], mem[mem_addr]};
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr + b[DM-1:0]] <= mem_wd[8*b +: 8];
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: byte-granular memory, sizes and extension from funct3
    function automatic int ref_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        logic [31:0] v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(a + i) % MEM_BYTES]) << (8 * i));
        if (f3[2] == 1'b0 && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (f3[2] == 1'b0 && sz == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = ref_size(f3);
        for (int i = 0; i < sz; i++) ref_mem[(a + i) % MEM_BYTES] = d[8*i +: 8];
    endtask

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a);
        return ((a % 4) + ref_size(f3) > 4) ? 4 : 3;
    endfunction

    logic [DM-1:0] cap_addr[8];
    logic [3:0]    cap_we  [8];
    logic [31:0]   cap_wd  [8];

    task automatic do_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output int lat, output int stalls, output bit ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = d;
        lat = 0; stalls = 0; ok = 1'b0; rd = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            cap_addr[c] = mem_addr; cap_we[c] = mem_we; cap_wd[c] = mem_wd;
            lat++;
            if (stall) stalls++;
            if (resp_valid) begin
                rd = rdata; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) check("response_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          cap_en;
        logic [8:0]  a0_addr; logic [3:0] a0_we; logic [31:0] a0_wd;
        logic [8:0]  a1_addr; logic [3:0] a1_we; logic [31:0] a1_wd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd;
        int lat, stalls;
        bit ok;
        logic [2:0] f3;
        logic [31:0] a, d;
        bit wr;

        for (int i = 0; i < MEM_BYTES; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end

        vecs[0]  = '{1, 3'b010, 32'h010, 32'hDEADBEEF, 0, 3, 1, 9'h010, 4'b1111, 32'hDEADBEEF, 0, 0, 0};
        vecs[1]  = '{1, 3'b010, 32'h010, 32'h80FF0000, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 3'b000, 32'h013, 0, 32'hFFFFFF80, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 3'b100, 32'h013, 0, 32'h00000080, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 3'b010, 32'h1FC, 32'h3344ABCD, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 3'b010, 32'h000, 32'h99881122, 0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 3'b010, 32'h1FE, 0, 32'h11223344, 4, 1, 9'h1FC, 4'b0000, 0, 9'h000, 4'b0000, 0};
        vecs[7]  = '{0, 3'b001, 32'h012, 0, 32'hFFFF80FF, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 3'b101, 32'h011, 0, 32'h0000FF00, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 3'b001, 32'h013, 32'h0000A55A, 0, 4, 1, 9'h010, 4'b1000, 32'h5A000000, 9'h014, 4'b0001, 32'h000000A5};
        vecs[10] = '{0, 3'b101, 32'h013, 0, 32'h0000A55A, 4, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 3'b001, 32'h013, 0, 32'hFFFFA55A, 4, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 3'b011, 32'hFFFF_F010, 0, 32'h5AFF0000, 3, 0, 0, 0, 0, 0, 0, 0};

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall",      32'(stall),      32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_mem_re",     32'(mem_re),     32'd0);
        check("reset_mem_we",     32'(mem_we),     32'd0);
        init_done = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_rdata", rdata, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, rd, lat, stalls, ok);
            if (vecs[i].wr) ref_store(vecs[i].f3, vecs[i].a, vecs[i].d);
            if (ok) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
                check($sformatf("vec%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_lat - 1));
            end
            if (vecs[i].cap_en) begin
                check($sformatf("vec%0d_a0_addr", i), 32'(cap_addr[1]), 32'(vecs[i].a0_addr));
                check($sformatf("vec%0d_a0_we", i),   32'(cap_we[1]),   32'(vecs[i].a0_we));
                check($sformatf("vec%0d_a0_wd", i),   cap_wd[1],        vecs[i].a0_wd);
                if (vecs[i].exp_lat == 4) begin
                    check($sformatf("vec%0d_a1_addr", i), 32'(cap_addr[2]), 32'(vecs[i].a1_addr));
                    check($sformatf("vec%0d_a1_we", i),   32'(cap_we[2]),   32'(vecs[i].a1_we));
                    check($sformatf("vec%0d_a1_wd", i),   cap_wd[2],        vecs[i].a1_wd);
                end
            end
        end

        // Reset while a crossing halfword store sits in its second beat
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b001; addr = 32'h023; wdata = 32'h00001234;
        @(negedge clk);
        #1;
        check("abort_a0_we", 32'(mem_we), 32'b1000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_a1_we",    32'(mem_we), 32'd0);
        check("abort_a1_stall", 32'(stall),  32'd0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        check("abort_idle_stall", 32'(stall),      32'd0);
        check("abort_idle_resp",  32'(resp_valid), 32'd0);
        check("abort_idle_we",    32'(mem_we),     32'd0);
        ref_mem[9'h023] = 8'h34;
        do_op(0, 3'b100, 32'h023, 0, rd, lat, stalls, ok);
        check("abort_a0_byte", rd, ref_load(3'b100, 32'h023));
        do_op(0, 3'b100, 32'h024, 0, rd, lat, stalls, ok);
        check("abort_a1_byte", rd, ref_load(3'b100, 32'h024));

        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            d  = $urandom;
            do_op(wr, f3, a, d, rd, lat, stalls, ok);
            if (ok) begin
                check("rand_rdata", rd, wr ? 32'd0 : ref_load(f3, a));
                check("rand_latency", 32'(lat), 32'(ref_latency(f3, a)));
                check("rand_stall", 32'(stalls), 32'(ref_latency(f3, a) - 1));
            end
            if (wr) ref_store(f3, a, d);
        end

        @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
            check("final_memory_bad_bytes", 32'(bad), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
